serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 97 +++++++++
 tb/tb_serial_subtractor.sv | 139 +++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, with a
// registered result and final borrow presented alongside a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepted start edge
// RUN   | one difference bit per cycle, WIDTH cycles total
// DONE  | diff/borrow_out just loaded; single-cycle done pulse
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res;
   logic             bw;
   logic [CW-1:0]    cnt;
   logic             d;
   logic             bw_next;
   logic [WIDTH:0]   res_cat;

   assign d       = a_sh[0] ^ b_sh[0] ^ bw;
   assign bw_next = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & bw) | (b_sh[0] & bw);
   // Shifting the new bit in at the top; dropping bit 0 keeps WIDTH=1 legal.
   assign res_cat = {d, res};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (cnt == LAST) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh       <= '0;
         b_sh       <= '0;
         res        <= '0;
         bw         <= 1'b0;
         cnt        <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh <= a;
                  b_sh <= b;
                  res  <= '0;
                  bw   <= 1'b0;
                  cnt  <= '0;
               end
            end
            RUN: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               bw   <= bw_next;
               res  <= res_cat[WIDTH:1];
               cnt  <= cnt + CW'(1);
               if (cnt == LAST) begin
                  diff       <= res_cat[WIDTH:1];
                  borrow_out <= bw_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8: result values,
// handshake timing, ignored start, operand changes and mid-operation reset.
module tb_serial_subtractor;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] diff;
   logic         borrow_out;
   logic         busy;
   logic         done;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .diff       (diff),
      .borrow_out (borrow_out),
      .busy       (busy),
      .done       (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   // Called at a falling edge with the DUT in IDLE; returns at a falling edge in IDLE.
   task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] ed, input logic eb, input bit glitch);
      int cyc;
      a     = av;
      b     = bv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      chk({tag, "_busy_start"}, busy, 1);
      chk({tag, "_done_early"}, done, 0);
      cyc = 0;
      while (done !== 1'b1 && cyc < 4 * W) begin
         @(negedge clk);
         cyc++;
         start = glitch && (cyc == 3);
         if (glitch && cyc == 3) a = '0;
      end
      start = 1'b0;
      chk({tag, "_latency"}, cyc, W);
      chk({tag, "_busy_in_done"}, busy, 0);
      chk({tag, "_diff"}, diff, ed);
      chk({tag, "_borrow"}, borrow_out, eb);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_diff_hold"}, diff, ed);
   endtask

   initial begin
      int dcount;
      logic [W-1:0] ra, rb;

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      a     = 8'd77;
      @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_diff", diff, 0);
      chk("reset_borrow", borrow_out, 0);
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);
      chk("idle_busy", busy, 0);

      run_op("basic",   8'd100, 8'd58,  8'd42,  1'b0, 1'b0);
      run_op("under57", 8'd5,   8'd7,   8'hFE,  1'b1, 1'b0);
      run_op("under01", 8'h00,  8'h01,  8'hFF,  1'b1, 1'b0);
      run_op("equal",   8'hA5,  8'hA5,  8'h00,  1'b0, 1'b0);
      run_op("ff_00",   8'hFF,  8'h00,  8'hFF,  1'b0, 1'b0);

      run_op("ignore",  8'd200, 8'd1,   8'd199, 1'b0, 1'b1);
      dcount = 0;
      repeat (W + 3) begin
         @(negedge clk);
         if (done === 1'b1) dcount++;
      end
      chk("ignore_no_extra_done", dcount, 0);
      chk("ignore_diff_hold", diff, 8'd199);

      a     = 8'd250;
      b     = 8'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_diff", diff, 0);
      chk("abort_borrow", borrow_out, 0);
      dcount = 0;
      repeat (2 * W) begin
         @(negedge clk);
         if (done === 1'b1) dcount++;
      end
      chk("abort_no_done", dcount, 0);
      run_op("after_abort", 8'd9, 8'd4, 8'd5, 1'b0, 1'b0);

      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         run_op("rand", ra, rb, W'(ra - rb), (ra < rb), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
